cond_unit: RTL and testbench

//  Consumer side of the ALU flag interface: latches NZCV from the ALU and decides per instruction

---
 rtl/cond_defs.sv | 46 ++++
 rtl/cond_check.sv | 44 ++++
 rtl/cond_unit.sv | 179 +++++++++++++++++
 tb/tb_cond_unit.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cond_defs.sv
// Shared types for the condition unit: condition codes, flag bundle, IT-block state.
// Latency: n/a (types and helpers only).
// Backpressure: n/a.
package cond_defs;

  // Condition-field encodings. NV (1111) is executed as AL.
  typedef enum logic [3:0] {
    EQ = 4'b0000,
    NE = 4'b0001,
    CS = 4'b0010,
    CC = 4'b0011,
    MI = 4'b0100,
    PL = 4'b0101,
    VS = 4'b0110,
    VC = 4'b0111,
    HI = 4'b1000,
    LS = 4'b1001,
    GE = 4'b1010,
    LT = 4'b1011,
    GT = 4'b1100,
    LE = 4'b1101,
    AL = 4'b1110,
    NV = 4'b1111
  } cond_e;

  typedef struct packed {
    logic n;
    logic z;
    logic c;
    logic v;
  } flags_t;

  typedef enum logic {
    IT_IDLE   = 1'b0,
    IT_ACTIVE = 1'b1
  } it_state_e;

  localparam flags_t FLAGS_RESET = '{n: 1'b0, z: 1'b0, c: 1'b0, v: 1'b0};

  // Condition a covered instruction actually uses: then-slots keep firstcond,
  // else-slots invert its low bit. AL with else becomes NV, which still executes.
  function automatic cond_e it_slot_cond(input logic [3:0] first_cond, input logic is_else);
    return cond_e'({first_cond[3:1], first_cond[0] ^ is_else});
  endfunction

endpackage

// File: rtl/cond_check.sv
// Purpose: evaluates one condition code against a flag set.
// Latency: purely combinational, zero cycles.
// Backpressure: none; a pure function of its inputs.
//
// Ports:
//   cond_i  condition code to test
//   flags_i N/Z/C/V flag set
//   pass_o  1 when the condition holds
module cond_check
  import cond_defs::*;
(
  input  cond_e  cond_i,
  input  flags_t flags_i,
  output logic   pass_o
);

  logic n_eq_v;

  assign n_eq_v = (flags_i.n == flags_i.v);

  always_comb begin
    pass_o = 1'b1;
    case (cond_i)
      EQ:      pass_o = flags_i.z;
      NE:      pass_o = ~flags_i.z;
      CS:      pass_o = flags_i.c;
      CC:      pass_o = ~flags_i.c;
      MI:      pass_o = flags_i.n;
      PL:      pass_o = ~flags_i.n;
      VS:      pass_o = flags_i.v;
      VC:      pass_o = ~flags_i.v;
      HI:      pass_o = flags_i.c & ~flags_i.z;
      LS:      pass_o = ~flags_i.c | flags_i.z;
      GE:      pass_o = n_eq_v;
      LT:      pass_o = ~n_eq_v;
      GT:      pass_o = ~flags_i.z & n_eq_v;
      LE:      pass_o = flags_i.z | ~n_eq_v;
      AL:      pass_o = 1'b1;
      NV:      pass_o = 1'b1;
      default: pass_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/cond_unit.sv
// Purpose: latches ALU flags, decides per instruction whether it executes, qualifies the
//          register/memory/PC write enables and sequences IT blocks of up to IT_MAX instructions.
// Latency: write-enable qualification is combinational (zero cycles); flags and IT state update at
//          the next rising edge and are seen by the following instruction.
// Backpressure: none; instr_valid_i low is a stall/bubble that freezes flags and IT state.
//
// Ports:
//   clk_i, rst_i                         clock, async active-high reset
//   instr_valid_i                        instruction present in execute this cycle
//   cond_i                               condition field (used outside IT blocks)
//   it_start_i, it_cond_i, it_len_i,     IT instruction: firstcond, covered count - 1,
//   it_te_i                              then/else mask for covered instructions 2..IT_MAX
//   flag_write_i, n_i, z_i, c_i, v_i     flag update request and new ALU flags
//   reg/mem/pc_write_i -> *_o            unqualified -> qualified write enables
//   cond_ex_o                            instruction passes its condition
//   flags_o                              registered {N,Z,C,V}
//   it_active_o, it_remaining_o          IT block in progress, covered slots left
//   it_err_o                             IT instruction issued inside an active block
module cond_unit
  import cond_defs::*;
#(
  parameter int IT_MAX = 4,
  localparam int IT_CW = $clog2(IT_MAX + 1)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              instr_valid_i,
  input  logic [3:0]        cond_i,
  input  logic              it_start_i,
  input  logic [3:0]        it_cond_i,
  input  logic [IT_CW-1:0]  it_len_i,
  input  logic [IT_MAX-2:0] it_te_i,
  input  logic              flag_write_i,
  input  logic              n_i,
  input  logic              z_i,
  input  logic              c_i,
  input  logic              v_i,
  input  logic              reg_write_i,
  input  logic              mem_write_i,
  input  logic              pc_write_i,
  output logic              reg_write_o,
  output logic              mem_write_o,
  output logic              pc_write_o,
  output logic              cond_ex_o,
  output logic [3:0]        flags_o,
  output logic              it_active_o,
  output logic [IT_CW-1:0]  it_remaining_o,
  output logic              it_err_o
);

  localparam logic [IT_CW-1:0] LEN_MAX = IT_CW'(IT_MAX - 1);
  localparam logic [IT_CW-1:0] ONE     = IT_CW'(1);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  it_state_e          state_q, state_d;
  flags_t             flags_q;
  logic [3:0]         it_cond_q, it_cond_d;
  // Bit 0 is the then(1)/else(0) flag for the slot currently in execute.
  logic [IT_MAX-1:0]  te_q, te_d;
  logic [IT_CW-1:0]   rem_q, rem_d;

  // ---------------------------------------------------------------------------
  // Condition evaluation (registered flags only, no bypass of this cycle's ALU result)
  // ---------------------------------------------------------------------------
  cond_e      eff_cond;
  logic       cond_pass;
  logic       it_issue;
  logic       flag_load;
  logic [IT_CW-1:0] len_clamped;

  always_comb begin
    if (state_q == IT_ACTIVE) begin
      eff_cond = it_slot_cond(it_cond_q, ~te_q[0]);
    end else begin
      eff_cond = cond_e'(cond_i);
    end
  end

  cond_check u_cond_check (
    .cond_i  (eff_cond),
    .flags_i (flags_q),
    .pass_o  (cond_pass)
  );

  // An IT instruction outside a block always executes; its own condition field is meaningless.
  assign it_issue = (state_q == IT_IDLE) & instr_valid_i & it_start_i;

  always_comb begin
    if (!instr_valid_i) begin
      cond_ex_o = 1'b1;
    end else if (it_issue) begin
      cond_ex_o = 1'b1;
    end else begin
      cond_ex_o = cond_pass;
    end
  end

  assign reg_write_o = reg_write_i & instr_valid_i & cond_ex_o;
  assign mem_write_o = mem_write_i & instr_valid_i & cond_ex_o;
  assign pc_write_o  = pc_write_i  & instr_valid_i & cond_ex_o;

  assign it_err_o = (state_q == IT_ACTIVE) & instr_valid_i & it_start_i;

  assign flag_load = instr_valid_i & flag_write_i & cond_ex_o;

  // An out-of-range length saturates to a full-size block rather than wrapping the counter.
  assign len_clamped = (it_len_i > LEN_MAX) ? LEN_MAX : it_len_i;

  // ---------------------------------------------------------------------------
  // IT sequencer: next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    it_cond_d = it_cond_q;
    te_d      = te_q;
    rem_d     = rem_q;
    case (state_q)
      IT_IDLE: begin
        if (it_issue) begin
          state_d   = IT_ACTIVE;
          it_cond_d = it_cond_i;
          te_d      = {it_te_i, 1'b1};  // first covered slot is always "then"
          rem_d     = len_clamped + ONE;
        end
      end
      IT_ACTIVE: begin
        // Every valid instruction uses a slot whether it executes or not; a nested IT is
        // just another covered no-op. A taken branch leaves the block early.
        if (instr_valid_i) begin
          if (pc_write_o || (rem_q == ONE)) begin
            state_d = IT_IDLE;
            rem_d   = '0;
            te_d    = '0;
          end else begin
            rem_d = rem_q - ONE;
            te_d  = te_q >> 1;
          end
        end
      end
      default: begin
        state_d = IT_IDLE;
        rem_d   = '0;
        te_d    = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= IT_IDLE;
      it_cond_q <= 4'b0000;
      te_q      <= '0;
      rem_q     <= '0;
    end else begin
      state_q   <= state_d;
      it_cond_q <= it_cond_d;
      te_q      <= te_d;
      rem_q     <= rem_d;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      flags_q <= FLAGS_RESET;
    end else if (flag_load) begin
      flags_q <= '{n: n_i, z: z_i, c: c_i, v: v_i};
    end
  end

  assign flags_o        = flags_q;
  assign it_active_o    = (state_q == IT_ACTIVE);
  assign it_remaining_o = rem_q;

endmodule

// File: tb/tb_cond_unit.sv
module tb_cond_unit;

  localparam int IT_MAX = 4;
  localparam int IT_CW  = $clog2(IT_MAX + 1);

  logic              clk_i = 1'b0;
  logic              rst_i;
  logic              instr_valid_i;
  logic [3:0]        cond_i;
  logic              it_start_i;
  logic [3:0]        it_cond_i;
  logic [IT_CW-1:0]  it_len_i;
  logic [IT_MAX-2:0] it_te_i;
  logic              flag_write_i;
  logic              n_i, z_i, c_i, v_i;
  logic              reg_write_i, mem_write_i, pc_write_i;
  logic              reg_write_o, mem_write_o, pc_write_o;
  logic              cond_ex_o;
  logic [3:0]        flags_o;
  logic              it_active_o;
  logic [IT_CW-1:0]  it_remaining_o;
  logic              it_err_o;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  cond_unit #(.IT_MAX(IT_MAX)) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .instr_valid_i  (instr_valid_i),
    .cond_i         (cond_i),
    .it_start_i     (it_start_i),
    .it_cond_i      (it_cond_i),
    .it_len_i       (it_len_i),
    .it_te_i        (it_te_i),
    .flag_write_i   (flag_write_i),
    .n_i            (n_i),
    .z_i            (z_i),
    .c_i            (c_i),
    .v_i            (v_i),
    .reg_write_i    (reg_write_i),
    .mem_write_i    (mem_write_i),
    .pc_write_i     (pc_write_i),
    .reg_write_o    (reg_write_o),
    .mem_write_o    (mem_write_o),
    .pc_write_o     (pc_write_o),
    .cond_ex_o      (cond_ex_o),
    .flags_o        (flags_o),
    .it_active_o    (it_active_o),
    .it_remaining_o (it_remaining_o),
    .it_err_o       (it_err_o)
  );

  always #5 clk_i = ~clk_i;

  // Condition codes
  localparam logic [3:0] C_EQ = 4'h0, C_NE = 4'h1, C_HI = 4'h8, C_LS = 4'h9,
                         C_GE = 4'hA, C_LT = 4'hB, C_AL = 4'hE;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    chk_cnt++;
    if (got === exp) begin
      pass_cnt++;
    end else begin
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Inputs are changed just after a falling edge; outputs are sampled 1ns later.
  task automatic idle_inputs();
    instr_valid_i = 1'b1;
    cond_i        = C_AL;
    it_start_i    = 1'b0;
    it_cond_i     = 4'h0;
    it_len_i      = '0;
    it_te_i       = '0;
    flag_write_i  = 1'b0;
    {n_i, z_i, c_i, v_i} = 4'b0000;
    reg_write_i   = 1'b0;
    mem_write_i   = 1'b0;
    pc_write_i    = 1'b0;
  endtask

  task automatic step();
    @(posedge clk_i);
    @(negedge clk_i);
    idle_inputs();
    #1;
  endtask

  task automatic load_flags(input logic [3:0] nzcv);
    cond_i       = C_AL;
    flag_write_i = 1'b1;
    {n_i, z_i, c_i, v_i} = nzcv;
    step();
  endtask

  initial begin
    idle_inputs();
    rst_i = 1'b1;

    // ---- 1: reset state ----
    cond_i      = C_EQ;
    reg_write_i = 1'b1;
    #2;
    chk("rst_flags", 8'(flags_o), 8'h0);
    chk("rst_active", 8'(it_active_o), 8'h0);
    chk("rst_remaining", 8'(it_remaining_o), 8'h0);
    chk("rst_eq_gated", 8'(reg_write_o), 8'h0);
    cond_i = C_AL;
    #1;
    chk("rst_al_pass", 8'(reg_write_o), 8'h1);
    @(negedge clk_i);
    rst_i = 1'b0;
    idle_inputs();
    #1;

    // ---- 2: flag load, visible next cycle ----
    flag_write_i = 1'b1;
    z_i          = 1'b1;
    #1;
    chk("z_load_flags_not_bypassed", 8'(flags_o), 8'h0);
    step();
    chk("z_loaded", 8'(flags_o), 8'b0100);
    cond_i      = C_EQ;
    mem_write_i = 1'b1;
    #1;
    chk("eq_pass_mem", 8'(mem_write_o), 8'h1);
    cond_i = C_NE;
    #1;
    chk("ne_gate_mem", 8'(mem_write_o), 8'h0);
    chk("ne_cond_ex", 8'(cond_ex_o), 8'h0);
    instr_valid_i = 1'b0;
    #1;
    chk("bubble_cond_ex", 8'(cond_ex_o), 8'h1);
    chk("bubble_mem_gated", 8'(mem_write_o), 8'h0);

    // ---- 3: signed / unsigned comparisons ----
    idle_inputs();
    load_flags(4'b1000);
    reg_write_i = 1'b1;
    cond_i = C_LT; #1; chk("lt_n1v0", 8'(reg_write_o), 8'h1);
    cond_i = C_GE; #1; chk("ge_n1v0", 8'(reg_write_o), 8'h0);
    idle_inputs();
    load_flags(4'b1001);
    reg_write_i = 1'b1;
    cond_i = C_GE; #1; chk("ge_n1v1", 8'(reg_write_o), 8'h1);
    idle_inputs();
    load_flags(4'b0010);
    reg_write_i = 1'b1;
    cond_i = C_HI; #1; chk("hi_c1z0", 8'(reg_write_o), 8'h1);
    cond_i = C_LS; #1; chk("ls_c1z0", 8'(reg_write_o), 8'h0);

    // ---- 4: IT EQ, len=2, slots then/else/then ----
    idle_inputs();
    load_flags(4'b0100);
    it_start_i = 1'b1;
    it_cond_i  = C_EQ;
    it_len_i   = 3'd2;
    it_te_i    = 3'b010;
    cond_i     = C_NE;  // would fail with Z=1; must be ignored
    #1;
    chk("it_issue_cond_ex", 8'(cond_ex_o), 8'h1);
    chk("it_issue_no_err", 8'(it_err_o), 8'h0);
    step();
    chk("it_active", 8'(it_active_o), 8'h1);
    chk("it_rem3", 8'(it_remaining_o), 8'd3);
    reg_write_i = 1'b1;
    cond_i      = C_NE;
    #1;
    chk("slot1_exec", 8'(reg_write_o), 8'h1);
    step();
    chk("it_rem2", 8'(it_remaining_o), 8'd2);
    instr_valid_i = 1'b0;
    step();
    chk("stall_holds_rem", 8'(it_remaining_o), 8'd2);
    reg_write_i = 1'b1;
    #1;
    chk("slot2_suppressed", 8'(reg_write_o), 8'h0);
    step();
    chk("it_rem1", 8'(it_remaining_o), 8'd1);
    reg_write_i = 1'b1;
    #1;
    chk("slot3_exec", 8'(reg_write_o), 8'h1);
    step();
    chk("it_done_idle", 8'(it_active_o), 8'h0);
    chk("it_done_rem0", 8'(it_remaining_o), 8'd0);

    // ---- 6: early exit on taken branch; AL-else executes ----
    it_start_i = 1'b1;
    it_cond_i  = C_AL;
    it_len_i   = 3'd3;
    it_te_i    = 3'b000;
    step();
    chk("it4_rem4", 8'(it_remaining_o), 8'd4);
    step();
    chk("it4_rem3", 8'(it_remaining_o), 8'd3);
    pc_write_i = 1'b1;
    #1;
    chk("al_else_branch_taken", 8'(pc_write_o), 8'h1);
    step();
    chk("branch_exit_idle", 8'(it_active_o), 8'h0);
    chk("branch_exit_rem0", 8'(it_remaining_o), 8'd0);
    // nested IT inside a block
    it_start_i = 1'b1;
    it_cond_i  = C_AL;
    it_len_i   = 3'd3;
    step();
    it_start_i = 1'b1;
    it_cond_i  = C_EQ;
    it_len_i   = 3'd0;
    #1;
    chk("nested_it_err", 8'(it_err_o), 8'h1);
    step();
    chk("nested_consumes_slot", 8'(it_remaining_o), 8'd3);
    chk("nested_still_active", 8'(it_active_o), 8'h1);
    // reset mid-block
    rst_i = 1'b1;
    #1;
    chk("midrst_inactive", 8'(it_active_o), 8'h0);
    chk("midrst_flags", 8'(flags_o), 8'h0);
    chk("midrst_rem", 8'(it_remaining_o), 8'd0);
    @(negedge clk_i);
    rst_i = 1'b0;
    idle_inputs();
    #1;

    // ---- 5: failed condition blocks flag write ----
    cond_i       = C_EQ;
    flag_write_i = 1'b1;
    n_i          = 1'b1;
    #1;
    chk("eq_fail_cond_ex", 8'(cond_ex_o), 8'h0);
    step();
    chk("flags_held", 8'(flags_o), 8'h0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

  // Safety net: the directed sequence above never waits on the DUT, but bound the run anyway.
  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
